spike_mac_scheduler: RTL and testbench

- Sequences one shared signed multiply-accumulate datapath (W_BITS weight × X_BITS input into an ACC_BITS accumulator) across N_NEURONS neurons, each with N_INPUTS synapses.
- After each neuron's accumulation, makes a stochastic annealing fire decision: the accumulator is compared against a threshold plus a temperature-scaled noise term taken from the external random_lfsr output.
- Sits between the weight/input memories, the random_lfsr and the spike consumer in the anneal spike-generating path.

---
 rtl/spike_mac_scheduler_if.sv | 31 +++
 rtl/spike_mac_scheduler.sv | 105 ++++++++++
 tb/tb_spike_mac_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/spike_mac_scheduler_if.sv
// spike_mac_scheduler_if: control, weight/input memory, noise and spike signals of the scheduler
interface spike_mac_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int N_INPUTS  = 8,
    parameter int W_BITS    = 5,
    parameter int X_BITS    = 8,
    parameter int ACC_BITS  = 21,
    parameter int RAND_BITS = 20
);
    localparam int AW = (N_NEURONS * N_INPUTS > 1) ? $clog2(N_NEURONS * N_INPUTS) : 1;
    localparam int XW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    logic                        start;
    logic signed [ACC_BITS-1:0]  thr;
    logic        [4:0]           temp_shift;
    logic        [RAND_BITS-1:0] rand_in;
    logic        [AW-1:0]        w_addr;
    logic signed [W_BITS-1:0]    w_data;
    logic        [XW-1:0]        x_addr;
    logic signed [X_BITS-1:0]    x_data;
    logic                        busy;
    logic                        done;
    logic        [N_NEURONS-1:0] spikes;
    modport master (
        output start, thr, temp_shift, rand_in, w_data, x_data,
        input  w_addr, x_addr, busy, done, spikes
    );
    modport slave (
        input  start, thr, temp_shift, rand_in, w_data, x_data,
        output w_addr, x_addr, busy, done, spikes
    );
endinterface

// File: rtl/spike_mac_scheduler.sv
// spike_mac_scheduler: time-shares one signed MAC over all neurons and makes a noisy threshold fire decision per neuron
module spike_mac_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int N_INPUTS  = 8,
    parameter int W_BITS    = 5,
    parameter int X_BITS    = 8,
    parameter int ACC_BITS  = 21,
    parameter int RAND_BITS = 20
) (
    input logic                   clk,
    input logic                   rst,
    spike_mac_scheduler_if.slave  bus
);
    localparam int AW = (N_NEURONS * N_INPUTS > 1) ? $clog2(N_NEURONS * N_INPUTS) : 1;
    localparam int XW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int NB = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int PW = W_BITS + X_BITS;
    localparam int EW = ACC_BITS + 2;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, FIRE, DONE} state_t;

    state_t                      state, state_n;
    logic        [NB-1:0]        n;
    logic        [XW-1:0]        i;
    logic signed [ACC_BITS-1:0]  acc;
    logic signed [ACC_BITS-1:0]  thr_q;
    logic        [4:0]           sh_q;
    logic        [AW-1:0]        w_addr_q;
    logic        [XW-1:0]        x_addr_q;
    logic        [N_NEURONS-1:0] spikes_q;
    logic        [AW-1:0]        cur_w;
    logic signed [PW-1:0]        prod;
    logic        [RAND_BITS-1:0] noise;
    logic signed [EW-1:0]        acc_x, thr_x, noise_x;
    logic                        fire, last_i, last_n;

    assign cur_w      = AW'(n) * AW'(N_INPUTS) + AW'(i);
    assign prod       = bus.w_data * bus.x_data;
    assign last_i     = i == XW'(N_INPUTS - 1);
    assign last_n     = n == NB'(N_NEURONS - 1);
    assign bus.spikes = spikes_q;

    // state register; reset aborts any run in progress
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // next state plus status and address outputs (addresses are live in FETCH, held otherwise)
    always_comb begin
        state_n    = state == IDLE  ? (bus.start ? FETCH : IDLE) :
                     state == FETCH ? (last_i ? DRAIN : FETCH) :
                     state == DRAIN ? FIRE :
                     state == FIRE  ? (last_n ? DONE : FETCH) : IDLE;
        bus.busy   = state inside {FETCH, DRAIN, FIRE};
        bus.done   = state == DONE;
        bus.w_addr = state == FETCH ? cur_w : w_addr_q;
        bus.x_addr = state == FETCH ? i : x_addr_q;
    end

    // fire decision: acc against threshold plus attenuated noise, widened so the sum cannot wrap
    always_comb begin
        noise   = sh_q >= 5'(RAND_BITS) ? '0 : bus.rand_in >> sh_q;
        acc_x   = EW'(acc);
        thr_x   = EW'(thr_q);
        noise_x = EW'(noise);
        fire    = acc_x > thr_x + noise_x;
    end

    // counters, accumulator, held addresses and the spike vector
    always_ff @(posedge clk) begin
        if (rst) begin
            n        <= '0;
            i        <= '0;
            acc      <= '0;
            thr_q    <= '0;
            sh_q     <= '0;
            w_addr_q <= '0;
            x_addr_q <= '0;
            spikes_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    thr_q    <= bus.thr;
                    sh_q     <= bus.temp_shift;
                    spikes_q <= '0;
                    n        <= '0;
                    i        <= '0;
                end
                FETCH: begin
                    w_addr_q <= cur_w;
                    x_addr_q <= i;
                    i        <= i + 1'b1;
                    acc      <= (i == '0) ? '0 : acc + ACC_BITS'(prod);
                end
                DRAIN: acc <= acc + ACC_BITS'(prod);
                FIRE: begin
                    spikes_q[n] <= fire;
                    n           <= n + 1'b1;
                    i           <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_mac_scheduler.sv
// tb_spike_mac_scheduler: directed and random runs checked against a dot-product reference model
module tb_spike_mac_scheduler;
    logic clk = 0;
    logic rst = 1;
    int cmps = 0;
    int errs = 0;
    logic signed [4:0] wmem [32];
    logic signed [7:0] xmem [8];
    int unsigned rv [45];

    spike_mac_scheduler_if bus ();
    spike_mac_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // synchronous memories: data valid one cycle after the address
    always @(posedge clk) begin
        bus.w_data <= wmem[bus.w_addr];
        bus.x_data <= xmem[bus.x_addr];
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        cmps++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic fill(input int w, input int x);
        for (int a = 0; a < 32; a++) wmem[a] = 5'(w);
        for (int j = 0; j < 8; j++) xmem[j] = 8'(x);
    endtask

    task automatic run(input string name, input int thr, input int sh, input int rc,
                       input int ign_at, input int rst_at);
        logic [3:0] es;
        int acc, noise, ew, ex;
        bit live;
        for (int c = 0; c < 45; c++) rv[c] = rc < 0 ? $urandom_range(0, (1 << 20) - 1) : rc;
        for (int k = 0; k < 4; k++) begin
            acc = 0;
            for (int j = 0; j < 8; j++) acc += int'(wmem[k*8+j]) * int'(xmem[j]);
            noise = sh >= 20 ? 0 : int'(rv[10*k+10] >> sh);
            es[k] = acc > thr + noise;
        end
        ew = 0;
        ex = 0;
        @(negedge clk);
        bus.start      = 1;
        bus.thr        = 21'(thr);
        bus.temp_shift = 5'(sh);
        bus.rand_in    = 20'(rv[0]);
        @(posedge clk);
        for (int c = 1; c < 45; c++) begin
            @(negedge clk);
            live = rst_at == 0 || c <= rst_at;
            if (!live) begin
                ew = 0;
                ex = 0;
            end else if (c <= 40) begin
                ex = (c - 1) % 10;
                if (ex > 7) ex = 7;
                ew = (c - 1) / 10 * 8 + ex;
            end
            chk($sformatf("%s busy c%0d", name, c), 32'(bus.busy), 32'(live && c <= 40));
            chk($sformatf("%s done c%0d", name, c), 32'(bus.done), 32'(live && c == 41));
            chk($sformatf("%s w_addr c%0d", name, c), 32'(bus.w_addr), 32'(ew));
            chk($sformatf("%s x_addr c%0d", name, c), 32'(bus.x_addr), 32'(ex));
            if (!live || c >= 41)
                chk($sformatf("%s spikes c%0d", name, c), 32'(bus.spikes), live ? 32'(es) : 32'(0));
            bus.start   = c == ign_at;
            bus.rand_in = 20'(rv[c]);
            rst         = c == rst_at;
        end
        bus.start = 0;
    endtask

    initial begin
        int t, s;
        bus.start      = 0;
        bus.thr        = '0;
        bus.temp_shift = '0;
        bus.rand_in    = '0;
        fill(11, 15);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset spikes", 32'(bus.spikes), 0);
        chk("reset w_addr", 32'(bus.w_addr), 0);
        chk("reset x_addr", 32'(bus.x_addr), 0);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("idle busy", 32'(bus.busy), 0);

        run("basic", 0, 31, -1, 0, 0);
        chk("basic spikes", 32'(bus.spikes), 32'hF);
        fill(11, -15);
        run("negative", 0, 31, -1, 0, 0);
        chk("negative spikes", 32'(bus.spikes), 32'h0);
        fill(11, 15);
        run("noise_sh0", 1000, 0, 512, 0, 0);
        chk("noise_sh0 spikes", 32'(bus.spikes), 32'h0);
        run("noise_sh2", 1000, 2, 512, 0, 0);
        chk("noise_sh2 spikes", 32'(bus.spikes), 32'hF);
        wmem[0]  = 5'(12);
        wmem[8]  = 5'(12);
        wmem[24] = 5'(12);
        run("strict", 1320, 31, -1, 0, 0);
        chk("strict spikes", 32'(bus.spikes), 32'hB);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 32; a++) wmem[a] = 5'($urandom);
            for (int j = 0; j < 8; j++) xmem[j] = 8'($urandom);
            t = int'($urandom_range(0, 8000)) - 4000;
            s = int'($urandom_range(6, 24));
            run($sformatf("rand%0d", r), t, s, -1, 0, 0);
        end

        run("ignore_start", 150, 12, -1, 10, 0);
        run("abort", 150, 12, -1, 0, 15);
        chk("abort stays idle", 32'(bus.busy), 0);
        for (int a = 0; a < 32; a++) wmem[a] = 5'($urandom);
        run("fresh", -300, 10, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
